// File: rtl/tmds_enc_mc_if.sv
// Pixel-side and serialiser-side bus of the multi-channel TMDS encoder.
// Optional TERC4 data-island inputs are present when TMDS_ENC_TERC4_EN is defined.
//
// Flow control: there is no ready signal. The encoder samples px_data_i,
// px_data_valid_i and ctrl_i (and the aux inputs) on every clock. It presents
// one symbol per lane on every clock, exactly two clocks later.
interface tmds_enc_mc_if #(
    parameter int CHANNELS = 3
);
    logic [CHANNELS*8-1:0]  px_data_i;
    logic                   px_data_valid_i;
    logic [CHANNELS*2-1:0]  ctrl_i;
    logic [CHANNELS*10-1:0] tmds_data_o;
    logic                   tmds_data_valid_o;
`ifdef TMDS_ENC_TERC4_EN
    logic [CHANNELS*4-1:0]  aux_data_i;
    logic                   aux_valid_i;

    modport master (
        output px_data_i, px_data_valid_i, ctrl_i, aux_data_i, aux_valid_i,
        input  tmds_data_o, tmds_data_valid_o
    );
    modport slave (
        input  px_data_i, px_data_valid_i, ctrl_i, aux_data_i, aux_valid_i,
        output tmds_data_o, tmds_data_valid_o
    );
`else
    modport master (
        output px_data_i, px_data_valid_i, ctrl_i,
        input  tmds_data_o, tmds_data_valid_o
    );
    modport slave (
        input  px_data_i, px_data_valid_i, ctrl_i,
        output tmds_data_o, tmds_data_valid_o
    );
`endif
endinterface

// File: rtl/tmds_enc_mc.sv
// Multi-channel DVI/HDMI TMDS 8b/10b encoder.
// The encoder has a two-stage pipeline:
//   - Stage 1 does transition minimisation (q_m).
//   - Stage 2 does DC balancing with a per-lane running disparity count, or
//     selects a control code during blanking.
// Optional feature macro: TMDS_ENC_TERC4_EN. It adds HDMI TERC4 data-island
// symbols, which are emitted when DE is low and aux_valid_i is high.
module tmds_enc_mc #(
    parameter int CHANNELS = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    tmds_enc_mc_if.slave     bus
);
    localparam logic [9:0] CTRL_00 = 10'b1101010100;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) s = s + 4'(v[i]);
        return s;
    endfunction

    // q_m[8] records which operation was used: 1 means XOR, 0 means XNOR.
    function automatic logic [8:0] minimise(input logic [7:0] d);
        logic [3:0] n1d;
        logic       use_xnor;
        logic [8:0] q;
        n1d      = popcount8(d);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++)
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~use_xnor;
        return q;
    endfunction

    // Returns {next_cnt[4:0], symbol[9:0]}.
    // The disparity arithmetic is done at 6 bits and then truncated.
    function automatic logic [14:0] balance(input logic [8:0] qm, input logic [4:0] cnt);
        logic [3:0]        n1;
        logic signed [5:0] c6;
        logic signed [5:0] diff;
        logic signed [5:0] two_qm8;
        logic signed [5:0] two_nqm8;
        logic signed [5:0] nxt;
        logic [9:0]        sym;
        n1       = popcount8(qm[7:0]);
        c6       = {cnt[4], cnt};
        diff     = $signed({1'b0, n1, 1'b0}) - 6'sd8;     // N1 - N0
        two_qm8  = $signed({4'b0, qm[8], 1'b0});
        two_nqm8 = $signed({4'b0, ~qm[8], 1'b0});
        if ((cnt == 5'd0) || (n1 == 4'd4)) begin
            sym = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            nxt = qm[8] ? (c6 + diff) : (c6 - diff);
        end else if ((!cnt[4] && (n1 > 4'd4)) || (cnt[4] && (n1 < 4'd4))) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            nxt = c6 + two_qm8 - diff;
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            nxt = c6 - two_nqm8 + diff;
        end
        return {5'(nxt), sym};
    endfunction

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = 10'b1101010100;
            2'b01:   s = 10'b0010101011;
            2'b10:   s = 10'b0101010100;
            default: s = 10'b1010101011;
        endcase
        return s;
    endfunction

`ifdef TMDS_ENC_TERC4_EN
    function automatic logic [9:0] terc4_code(input logic [3:0] d);
        logic [9:0] s;
        case (d)
            4'h0: s = 10'b1010011100;  4'h1: s = 10'b1001100011;
            4'h2: s = 10'b1011100100;  4'h3: s = 10'b1011100010;
            4'h4: s = 10'b0101110001;  4'h5: s = 10'b0100011110;
            4'h6: s = 10'b0110001110;  4'h7: s = 10'b0100111100;
            4'h8: s = 10'b1011001100;  4'h9: s = 10'b0100111001;
            4'hA: s = 10'b0110011100;  4'hB: s = 10'b1011000110;
            4'hC: s = 10'b1010001110;  4'hD: s = 10'b1001110001;
            4'hE: s = 10'b0101100011;  default: s = 10'b1011000011;
        endcase
        return s;
    endfunction

    logic                         aux_valid_q;
    logic [CHANNELS-1:0][3:0]     aux_q;
`endif

    logic [CHANNELS-1:0][7:0]     px;
    logic [CHANNELS-1:0][8:0]     qm_d, qm_q;
    logic                         de_q;
    logic [CHANNELS-1:0][1:0]     ctrl_q;
    logic [CHANNELS-1:0][9:0]     sym_d, sym_q;
    logic [CHANNELS-1:0][4:0]     cnt_d, cnt_q;
    logic                         valid_q;

    assign px = bus.px_data_i;

    // Stage 1 combinational logic: transition-minimise every lane.
    always_comb begin
        for (int n = 0; n < CHANNELS; n++) qm_d[n] = minimise(px[n]);
    end

    // Stage 1 registers: q_m, together with DE and the control/aux inputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            qm_q        <= '0;
            de_q        <= 1'b0;
            ctrl_q      <= '0;
`ifdef TMDS_ENC_TERC4_EN
            aux_valid_q <= 1'b0;
            aux_q       <= '0;
`endif
        end else begin
            qm_q        <= qm_d;
            de_q        <= bus.px_data_valid_i;
            ctrl_q      <= bus.ctrl_i;
`ifdef TMDS_ENC_TERC4_EN
            aux_valid_q <= bus.aux_valid_i;
            aux_q       <= bus.aux_data_i;
`endif
        end
    end

    // Stage 2 combinational logic, in priority order:
    //   - video DC balancing, when DE is high;
    //   - otherwise a TERC4 or control symbol.
    // The disparity count is cleared outside active video.
    always_comb begin
        for (int n = 0; n < CHANNELS; n++) begin
            sym_d[n] = ctrl_code(ctrl_q[n]);
            cnt_d[n] = '0;
            if (de_q) begin
                {cnt_d[n], sym_d[n]} = balance(qm_q[n], cnt_q[n]);
            end
`ifdef TMDS_ENC_TERC4_EN
            else if (aux_valid_q) begin
                sym_d[n] = terc4_code(aux_q[n]);
            end
`endif
        end
    end

    // Stage 2 registers: output symbols, disparity counters and delayed DE.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sym_q   <= {CHANNELS{CTRL_00}};
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sym_q   <= sym_d;
            cnt_q   <= cnt_d;
            valid_q <= de_q;
        end
    end

    assign bus.tmds_data_o       = sym_q;
    assign bus.tmds_data_valid_o = valid_q;
endmodule

// File: tb/tb_tmds_enc_mc.sv
// Self-checking bench for tmds_enc_mc.
// - A reference 8b/10b model predicts each symbol when its stimulus is driven.
// - The prediction is queued and then compared two clocks later.
// - Video symbols are also decoded back to bytes.
// - Running disparity is bounded at every end of active video.
module tb_tmds_enc_mc;
    localparam int CH = 3;
    localparam int W  = CH*10 + 1;
    localparam logic [9:0] C00 = 10'b1101010100;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    tmds_enc_mc_if #(.CHANNELS(CH)) bus();

    tmds_enc_mc #(.CHANNELS(CH)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    // Clock.
    always #5 clk = ~clk;

    logic [W-1:0]  exp_q[$];
    logic [CH*8:0] stim_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int cnt_m[CH];
    int rd[CH];
    logic de_prev;
    logic [9:0] ctrl_tab[4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
`ifdef TMDS_ENC_TERC4_EN
    logic [9:0] terc_tab[16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    logic          aux_v = 1'b0;
    logic [CH*4-1:0] aux_d = '0;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference DVI encoder for one video byte. It updates the model disparity of the lane.
    function automatic logic [9:0] ref_video(input int lane, input logic [7:0] d);
        logic [8:0] qm;
        logic [9:0] s;
        int n1d, n1, n0;
        bit xn;
        n1d = 0;
        for (int i = 0; i < 8; i++) n1d += int'(d[i]);
        xn = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !xn;
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
        n0 = 8 - n1;
        if (cnt_m[lane] == 0 || n1 == n0) begin
            s = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            if (qm[8]) cnt_m[lane] += n1 - n0;
            else       cnt_m[lane] += n0 - n1;
        end else if ((cnt_m[lane] > 0 && n1 > n0) || (cnt_m[lane] < 0 && n0 > n1)) begin
            s = {1'b1, qm[8], ~qm[7:0]};
            cnt_m[lane] += 2*int'(qm[8]) + n0 - n1;
        end else begin
            s = {1'b0, qm[8], qm[7:0]};
            cnt_m[lane] += -2*int'(!qm[8]) + n1 - n0;
        end
        return s;
    endfunction

    function automatic logic [W-1:0] model(input logic de, input logic [CH*8-1:0] px,
                                           input logic [CH*2-1:0] ctrl);
        logic [W-1:0] r;
        r = '0;
        r[W-1] = de;
        for (int n = 0; n < CH; n++) begin
            logic [9:0] s;
            if (de) begin
                s = ref_video(n, px[8*n +: 8]);
            end else begin
                cnt_m[n] = 0;
                s = ctrl_tab[ctrl[2*n +: 2]];
`ifdef TMDS_ENC_TERC4_EN
                if (aux_v) s = terc_tab[aux_d[4*n +: 4]];
`endif
            end
            r[10*n +: 10] = s;
        end
        return r;
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] d, b;
        d = s[9] ? ~s[7:0] : s[7:0];
        b[0] = d[0];
        for (int i = 1; i < 8; i++) b[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return b;
    endfunction

    function automatic logic [CH*8-1:0] rand_px();
        logic [CH*8-1:0] v;
        for (int n = 0; n < CH; n++) v[8*n +: 8] = 8'($urandom_range(0, 255));
        return v;
    endfunction

    function automatic logic [CH*2-1:0] rand_ctrl();
        logic [CH*2-1:0] v;
        for (int n = 0; n < CH; n++) v[2*n +: 2] = 2'($urandom_range(0, 3));
        return v;
    endfunction

    // Driver and scoreboard, one pixel clock per call:
    // - compare the output due now, which comes from the stimulus two clocks ago;
    // - then drive new stimulus and queue its prediction.
    task automatic step(input logic de, input logic [CH*8-1:0] px, input logic [CH*2-1:0] ctrl);
        logic [W-1:0]  got, exp;
        logic [CH*8:0] st;
        @(negedge clk);
        got = {bus.tmds_data_valid_o, bus.tmds_data_o};
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: got output %h with no expected entry", got);
        end else begin
            exp = exp_q.pop_front();
            st  = stim_q.pop_front();
            check("symbol", 64'(got), 64'(exp));
            for (int n = 0; n < CH; n++) begin
                if (st[CH*8]) begin
                    check("decode", 64'(decode(got[10*n +: 10])), 64'(st[8*n +: 8]));
                    rd[n] += 2*$countones(got[10*n +: 10]) - 10;
                end else if (de_prev) begin
                    check("disparity_bound", 64'(rd[n] >= -10 && rd[n] <= 10), 64'd1);
                    rd[n] = 0;
                end
            end
            de_prev = st[CH*8];
        end
        bus.px_data_valid_i = de;
        bus.px_data_i       = px;
        bus.ctrl_i          = ctrl;
`ifdef TMDS_ENC_TERC4_EN
        bus.aux_valid_i     = aux_v;
        bus.aux_data_i      = aux_d;
`endif
        exp_q.push_back(model(de, px, ctrl));
        stim_q.push_back({de, px});
    endtask

    // Reset: assert off-edge and check the asynchronous response.
    // Hold with random inputs, then release with idle inputs.
    task automatic apply_reset(input int hold);
        rst_n = 1'b0;
        #1;
        check("rst_async", 64'({bus.tmds_data_valid_o, bus.tmds_data_o}), 64'({1'b0, {CH{C00}}}));
        repeat (hold) begin
            @(negedge clk);
            bus.px_data_valid_i = 1'($urandom_range(0, 1));
            bus.px_data_i       = rand_px();
            bus.ctrl_i          = rand_ctrl();
            check("rst_hold", 64'({bus.tmds_data_valid_o, bus.tmds_data_o}), 64'({1'b0, {CH{C00}}}));
        end
        @(negedge clk);
        bus.px_data_valid_i = 1'b0;
        bus.px_data_i       = '0;
        bus.ctrl_i          = '0;
`ifdef TMDS_ENC_TERC4_EN
        aux_v = 1'b0;
        bus.aux_valid_i = 1'b0;
        bus.aux_data_i  = '0;
`endif
        rst_n = 1'b1;
        exp_q.delete();
        stim_q.delete();
        for (int n = 0; n < CH; n++) begin
            cnt_m[n] = 0;
            rd[n]    = 0;
        end
        de_prev = 1'b0;
        // Two cycles of output still come from cleared pipeline state.
        repeat (2) begin
            exp_q.push_back({1'b0, {CH{C00}}});
            stim_q.push_back('0);
        end
    endtask

    initial begin
        bus.px_data_valid_i = 1'b0;
        bus.px_data_i       = rand_px();
        bus.ctrl_i          = rand_ctrl();
`ifdef TMDS_ENC_TERC4_EN
        bus.aux_valid_i     = 1'b0;
        bus.aux_data_i      = '0;
`endif
        de_prev = 1'b0;
        #2;
        apply_reset(4);

        // Control codes: lane 0 = 11 first, then assorted codes.
        step(1'b0, '0, 6'b000011);
        step(1'b0, '0, 6'b100100);
        step(1'b0, '0, 6'b011011);

        // Three zero bytes from cnt = 0, expecting 0x100, 0x3FF, 0x100.
        repeat (3) step(1'b1, '0, '0);
        step(1'b0, '0, '0);

        // XNOR path with all-ones bytes.
        repeat (4) step(1'b1, {CH{8'hFF}}, '0);
        step(1'b0, '0, '0);

        // Directed mixed bytes on distinct lanes.
        step(1'b1, {8'h55, 8'hAA, 8'h10}, '0);
        step(1'b1, {8'h0F, 8'hF0, 8'h1E}, '0);
        step(1'b1, {8'h80, 8'h01, 8'hE1}, '0);
        step(1'b0, '0, 6'b110001);

        // DE toggling every cycle.
        for (int i = 0; i < 12; i++) step(1'((i % 2) == 0), rand_px(), rand_ctrl());

        // Random video with blanking gaps.
        for (int i = 0; i < 3000; i++) step(1'($urandom_range(0, 15) != 0), rand_px(), rand_ctrl());

        // Reset in mid-video with a non-zero cnt.
        step(1'b1, '0, '0);
        step(1'b1, '0, '0);
        step(1'b1, {8'h33, 8'h00, 8'hFF}, '0);
        #3;
        apply_reset(3);
        repeat (3) step(1'b1, '0, '0);
        step(1'b0, '0, 6'b000011);

`ifdef TMDS_ENC_TERC4_EN
        // Data island: nibble 5 on lane 1, then DE taking priority over aux.
        aux_v = 1'b1;
        aux_d = {4'h0, 4'h5, 4'h0};
        step(1'b0, '0, '0);
        for (int i = 0; i < 6; i++) begin
            aux_d = 12'($urandom_range(0, 4095));
            step(1'b0, '0, rand_ctrl());
        end
        step(1'b1, {8'h12, 8'h34, 8'h56}, '0);
        aux_v = 1'b0;
        step(1'b0, '0, '0);
`endif

        // Drain the pipeline.
        repeat (2) step(1'b0, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
